// File: rtl/hc_enc_stream.sv
// Streaming Hamming encoder feeding the downstream decoder.
// Words enter on a valid/ready handshake, are encoded combinationally and
// land in a 2-entry FIFO whose head drives the output handshake. A one-shot
// error injector can corrupt a single bit of the next accepted word so the
// decoder's correction path can be exercised in-system.
module hc_enc_stream #(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int CNT_WD  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WD-1:0]        i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [DATA_WD+CHK_WD-1:0] o_enc_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  input  logic                      i_inj_req,
  input  logic [CHK_WD-1:0]         i_inj_pos,
  output logic                      o_inj_armed,
  output logic [CNT_WD-1:0]         o_word_cnt
);
  localparam int N = DATA_WD + CHK_WD;

  generate
    if (N > (2**CHK_WD) - 1) begin : g_bad_params
      $error("hc_enc_stream: DATA_WD+CHK_WD must be <= 2**CHK_WD-1");
    end
  endgenerate

  // Hamming position (1-based) of data bit k: k-th non-power-of-two index.
  function automatic int dpos(input int k);
    int seen;
    seen = 0;
    for (int p = 1; p < 1024; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == k) return p;
        seen++;
      end
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------------
  // Encoder: data bits scattered to their positions, check bit 2**j is the
  // parity of every data bit whose position has bit j set.
  // ---------------------------------------------------------------------
  logic [N-1:0]                     code_w;
  logic [CHK_WD-1:0][DATA_WD-1:0]   chk_sel;

  for (genvar k = 0; k < DATA_WD; k++) begin : g_data
    assign code_w[dpos(k)-1] = i_data[k];
  end

  for (genvar j = 0; j < CHK_WD; j++) begin : g_chk
    for (genvar k = 0; k < DATA_WD; k++) begin : g_sel
      assign chk_sel[j][k] = ((dpos(k) >> j) & 1) != 0;
    end
    if ((1 << j) <= N) begin : g_bit
      assign code_w[(1<<j)-1] = ^(i_data & chk_sel[j]);
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [N-1:0]        mem_q [0:1];
  logic                wr_q, rd_q;
  logic [1:0]          cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [CHK_WD-1:0]   pos_q, pos_d;
  logic [CNT_WD-1:0]   wcnt_q;

  logic                push, pop, pos_ok;
  logic [N-1:0]        flip_w, store_w;

  assign o_ready     = (cnt_q != 2'd2);
  assign o_valid     = (cnt_q != 2'd0);
  assign o_enc_data  = o_valid ? mem_q[rd_q] : '0;
  assign o_inj_armed = armed_q;
  assign o_word_cnt  = wcnt_q;

  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  assign pos_ok  = (i_inj_pos != '0) && (int'(i_inj_pos) <= N);
  // Only a position armed before this edge may corrupt the word taken now.
  assign flip_w  = armed_q ? (N'(1) << (pos_q - CHK_WD'(1))) : '0;
  assign store_w = code_w ^ flip_w;

  // Next FIFO occupancy and injection arming.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    pos_d   = pos_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    // A fresh valid request wins over consumption, so it re-arms.
    if (i_inj_req && pos_ok) begin
      armed_d = 1'b1;
      pos_d   = i_inj_pos;
    end else if (push && armed_q) begin
      armed_d = 1'b0;
    end
  end

  // FIFO storage, pointers, delivered-word counter and injection state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      armed_q  <= 1'b0;
      pos_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= store_w;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q   <= ~rd_q;
        wcnt_q <= wcnt_q + CNT_WD'(1);
      end
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: doc/hc_enc_stream.md
Name: hc_enc_stream

Overview:
Streaming Hamming encoder that sits directly upstream of the Hamming decoder and produces its DATA_WD+CHK_WD codewords.
- Accepts data words over a valid/ready handshake, encodes them, and buffers results in a 2-entry output FIFO.
- Supports single-shot single-bit error injection so the downstream decoder's correction path can be exercised in-system.
- Counts delivered codewords.

Parameters:
DATA_WD, 4, data bits per word
CHK_WD, 3, check bits per word; DATA_WD+CHK_WD <= 2**CHK_WD-1 is required, elaboration error otherwise
CNT_WD, 16, width of delivered-word counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_data  in  DATA_WD  data word to encode
i_valid  in  1  i_data valid
o_ready  out  1  block can accept i_data
o_enc_data  out  DATA_WD+CHK_WD  codeword; bit k = Hamming position k+1
o_valid  out  1  o_enc_data valid
i_ready  in  1  downstream accepts o_enc_data
i_inj_req  in  1  one-cycle request to arm error injection
i_inj_pos  in  CHK_WD  Hamming position (1..DATA_WD+CHK_WD) to flip
o_inj_armed  out  1  injection armed, not yet consumed
o_word_cnt  out  CNT_WD  count of codewords delivered, wraps

Behaviour:
- Reset values (async assert; release synchronous to i_clk): FIFO empty, o_valid=0, o_enc_data=0, o_ready=1, o_inj_armed=0, o_word_cnt=0. A reset mid-operation discards FIFO contents and any armed injection.
- Encoding: positions 1..N, where N=DATA_WD+CHK_WD.
  - Positions that are powers of two (1,2,4,...) hold check bits.
  - Data bits d0..d(DATA_WD-1) fill the remaining positions in ascending order. For 4/3 this is d0@3, d1@5, d2@6, d3@7.
  - The check bit at position 2**j is the XOR of all data positions whose index has bit j set. For 4/3 this gives p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
- Input handshake: a word is accepted on a rising edge with i_valid&&o_ready. o_ready = (FIFO count < 2), driven from registered count with no combinational path from i_ready.
- Latency: a word accepted at edge n has its codeword at FIFO head and o_valid=1 after edge n, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained while i_ready=1.
- Output handshake: a word is delivered on an edge with o_valid&&i_ready. FIFO pops; o_word_cnt increments modulo 2**CNT_WD.
- While o_valid=1 and i_ready=0, o_enc_data stays stable.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, order preserved (FIFO, no reordering).
  - Count 2: o_ready=0, input ignored.
  - Count 0: o_valid=0; pop is impossible.
- Error injection:
  - i_inj_req=1 with 1 <= i_inj_pos <= N arms injection from the next edge: o_inj_armed=1, position latched.
  - i_inj_pos=0 or >N: request ignored, armed state unchanged.
  - A request while already armed overwrites the latched position.
  - The first word accepted on an edge where o_inj_armed was already 1 is stored with bit (pos-1) inverted. o_inj_armed clears on that same edge.
  - A request in the same cycle as an accept does not affect that word.
  - A request in the same cycle as consumption re-arms with the new position.
- Counter is not affected by injection.

Test Plan:
- Reset, then i_data=4'b1011, i_valid=1 for one cycle, i_ready=1 -> o_valid=1 one cycle later with o_enc_data=7'h55; o_word_cnt=1 after the handshake.
- Back-to-back 4'h0, 4'h1, 4'hF with i_ready=1 -> 7'h00, 7'h07, 7'h7F on consecutive cycles; o_ready stays 1.
- i_ready=0, push 3 words -> o_ready low after 2 accepted; 3rd held. Raise i_ready -> 3 words delivered in order; o_word_cnt=3.
- i_inj_req with pos=3, then send 4'b1011 -> o_enc_data=7'h51 (bit 2 flipped); o_inj_armed clears. Next word 4'b1011 -> 7'h55.
- i_inj_req with pos=0 and pos=7 on 3/4 config, each followed by 4'h0 -> pos 0 ignored (7'h00); pos 7 yields 7'h40.
- Assert i_rst with 2 words queued and injection armed -> immediately o_valid=0, o_ready=1, o_inj_armed=0, o_word_cnt=0; after release, 4'h1 encodes to 7'h07 uncorrupted.
